// File: rtl/fp_adder_loader_pkg.sv
// Shared definitions for the serial FP adder loader: FSM states, setup-byte
// layout and default operand/setup widths shared with the adder top.
package fp_adder_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      DATA  = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam int SUBOP_MSB  = 7;
   localparam int SUBOP_LSB  = 5;
   localparam int LANE_LSB   = 1;
   localparam int CLKSEL_BIT = 0;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_SETUP_W = 8;
   localparam int CNT_W       = 7;

   function automatic logic [DEF_SETUP_W-1:0] build_setup(input logic [2:0] sub_op,
                                                          input logic [3:0] lane_en,
                                                          input logic       ext_clk_sel);
      logic [DEF_SETUP_W-1:0] s;
      s                       = '0;
      s[SUBOP_MSB:SUBOP_LSB]  = sub_op;
      s[LANE_LSB +: 4]        = lane_en;
      s[CLKSEL_BIT]           = ext_clk_sel;
      return s;
   endfunction

endpackage

// File: rtl/fp_adder_loader_piso_shifter.sv
// Parallel-load, MSB-first shift-out register. With ROTATE set the MSB wraps
// back into the LSB so the loaded word repeats every W shifts.
module piso_shifter #(
   parameter int W      = 16,
   parameter bit ROTATE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         dout
);

   logic [W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load)
         sr_d = din;
      else if (shift)
         sr_d = {sr_q[W-2:0], ROTATE ? sr_q[W-1] : 1'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign dout = sr_q[W-1];

endmodule

// File: rtl/fp_adder_loader.sv
// Loader for the four-operand serial FP adder: captures one command, shifts the
// setup byte then the operands out under wr_out, then waits for input_rdy.
module fp_adder_loader
   import fp_adder_loader_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SETUP_W = DEF_SETUP_W,
   parameter int TIMEOUT = 64
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] op_c,
   input  logic [WIDTH-1:0] op_d,
   input  logic [2:0]       sub_op,
   input  logic [3:0]       lane_en,
   input  logic             ext_clk_sel,
   input  logic             input_rdy_in,
   output logic             serial1_out,
   output logic             serial2_out,
   output logic             serial3_out,
   output logic             serial4_out,
   output logic             setup_serial_out,
   output logic             wr_out,
   output logic             busy,
   output logic             done,
   output logic             timeout_err
);

   localparam int NUM_LANES = 4;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             terr_q, terr_d;
   logic             load;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      terr_d  = terr_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (cmd_valid) begin
               load    = 1'b1;
               terr_d  = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: if (cnt_q == CNT_W'(SETUP_W-1)) begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: begin
            // input_rdy takes priority over a timeout landing on the same cycle
            if (input_rdy_in) begin
               state_d = DONE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
               terr_d  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   logic shift_setup, shift_data;
   assign shift_setup = (state_q == SETUP) || (state_q == DATA);
   assign shift_data  = (state_q == DATA);

   // lane i drives serial(i+1); op_a sits on the top lane (serial4)
   logic [NUM_LANES-1:0][WIDTH-1:0] lane_din;
   logic [NUM_LANES-1:0]            lane_dout;
   assign lane_din = {op_a, op_b, op_c, op_d};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      piso_shifter #(.W(WIDTH), .ROTATE(1'b0)) u_lane (
         .clk   (clk_in),
         .rst   (rst_in),
         .load  (load),
         .shift (shift_data),
         .din   (lane_din[i]),
         .dout  (lane_dout[i])
      );
   end

   // rotating setup register re-sends S during DATA so the adder ends holding S
   logic setup_dout;
   piso_shifter #(.W(SETUP_W), .ROTATE(1'b1)) u_setup (
      .clk   (clk_in),
      .rst   (rst_in),
      .load  (load),
      .shift (shift_setup),
      .din   (SETUP_W'(build_setup(sub_op, lane_en, ext_clk_sel))),
      .dout  (setup_dout)
   );

   assign serial1_out      = shift_data & lane_dout[0];
   assign serial2_out      = shift_data & lane_dout[1];
   assign serial3_out      = shift_data & lane_dout[2];
   assign serial4_out      = shift_data & lane_dout[3];
   assign setup_serial_out = shift_setup & setup_dout;
   assign wr_out           = shift_setup;
   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign cmd_ready        = (state_q == IDLE);
   assign timeout_err      = terr_q;

endmodule
